shot_ctrl: RTL and testbench



---
 rtl/shot_ctrl_if.sv | 62 ++++++
 rtl/shot_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_shot_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shot_ctrl_if.sv
// Shot request/result handshake, BFS hand-off and board-memory bus of the shot controller.
// master = controller side, slave = environment (player, BFS stage, board memory).
interface shot_ctrl_if #(
    parameter int unsigned CNT_W = 3
);
    localparam int unsigned COORD_W = 3;
    localparam int unsigned CELL_W  = 2;

    logic               shot_valid;
    logic [COORD_W-1:0] shot_x;
    logic [COORD_W-1:0] shot_y;
    logic               shot_ready;

    logic               res_valid;
    logic [1:0]         res_code;
    logic [CNT_W-1:0]   ships_left;
    logic               game_over;

    logic [COORD_W-1:0] bfs_x;
    logic [COORD_W-1:0] bfs_y;
    logic               bfs_start;
    logic               bfs_done;
    logic               bfs_sink;

    logic [COORD_W-1:0] bfs_mem_addr_x;
    logic [COORD_W-1:0] bfs_mem_addr_y;
    logic               bfs_mem_wr_en;
    logic [CELL_W-1:0]  bfs_mem_wr_data;
    logic               bfs_mem_in_valid;
    logic [CELL_W-1:0]  bfs_mem_rd_data;
    logic               bfs_mem_ready;

    logic [COORD_W-1:0] mem_addr_x;
    logic [COORD_W-1:0] mem_addr_y;
    logic               mem_wr_en;
    logic [CELL_W-1:0]  mem_wr_data;
    logic               mem_in_valid;
    logic [CELL_W-1:0]  mem_rd_data;
    logic               mem_ready;

    modport master (
        input  shot_valid, shot_x, shot_y,
        input  bfs_done, bfs_sink,
        input  bfs_mem_addr_x, bfs_mem_addr_y, bfs_mem_wr_en, bfs_mem_wr_data, bfs_mem_in_valid,
        input  mem_rd_data, mem_ready,
        output shot_ready, res_valid, res_code, ships_left, game_over,
        output bfs_x, bfs_y, bfs_start,
        output bfs_mem_rd_data, bfs_mem_ready,
        output mem_addr_x, mem_addr_y, mem_wr_en, mem_wr_data, mem_in_valid
    );

    modport slave (
        output shot_valid, shot_x, shot_y,
        output bfs_done, bfs_sink,
        output bfs_mem_addr_x, bfs_mem_addr_y, bfs_mem_wr_en, bfs_mem_wr_data, bfs_mem_in_valid,
        output mem_rd_data, mem_ready,
        input  shot_ready, res_valid, res_code, ships_left, game_over,
        input  bfs_x, bfs_y, bfs_start,
        input  bfs_mem_rd_data, bfs_mem_ready,
        input  mem_addr_x, mem_addr_y, mem_wr_en, mem_wr_data, mem_in_valid
    );
endinterface

// File: rtl/shot_ctrl.sv
// Shot front-end: reads the targeted board cell, classifies miss/repeat/hit, runs the
// sink-detection BFS stage on hits while lending it the board-memory port, tracks ships.
module shot_ctrl #(
    parameter int unsigned WIDTH     = 6,
    parameter int unsigned NUM_SHIPS = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic          clk,
    input  logic          rstn,
    shot_ctrl_if.master   bus
);
    localparam int unsigned COORD_W = 3;
    localparam int unsigned CELL_W  = 2;

    localparam logic [1:0] CODE_MISS   = 2'b00;
    localparam logic [1:0] CODE_HIT    = 2'b01;
    localparam logic [1:0] CODE_SINK   = 2'b10;
    localparam logic [1:0] CODE_REPEAT = 2'b11;

    localparam logic [CELL_W-1:0] CELL_WATER = 2'b00;
    localparam logic [CELL_W-1:0] CELL_SUB   = 2'b01;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        BFS_RUN = 3'd3,
        BFS_REL = 3'd4,
        RESULT  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               sink_q, sink_d;
    logic               res_valid_q, res_valid_d;
    logic [1:0]         res_code_q, res_code_d;
    logic [CNT_W-1:0]   ships_q, ships_d;
    logic               game_over_q, game_over_d;
    logic               bfs_start_q, bfs_start_d;
    logic [COORD_W-1:0] bfs_x_q, bfs_x_d;
    logic [COORD_W-1:0] bfs_y_q, bfs_y_d;
    logic               rd_valid_q, rd_valid_d;
    logic               grant_q, grant_d;
    logic               shot_ready_c;
    logic               coord_bad_c;

    assign shot_ready_c = (state_q == IDLE) && !game_over_q;
    assign coord_bad_c  = (bus.shot_x >= COORD_W'(WIDTH)) || (bus.shot_y >= COORD_W'(WIDTH));

    // State and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            sink_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_code_q  <= CODE_MISS;
            ships_q     <= CNT_W'(NUM_SHIPS);
            game_over_q <= 1'b0;
            bfs_start_q <= 1'b0;
            bfs_x_q     <= '0;
            bfs_y_q     <= '0;
            rd_valid_q  <= 1'b0;
            grant_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            sink_q      <= sink_d;
            res_valid_q <= res_valid_d;
            res_code_q  <= res_code_d;
            ships_q     <= ships_d;
            game_over_q <= game_over_d;
            bfs_start_q <= bfs_start_d;
            bfs_x_q     <= bfs_x_d;
            bfs_y_q     <= bfs_y_d;
            rd_valid_q  <= rd_valid_d;
            grant_q     <= grant_d;
        end
    end

    // Next state; registered outputs are computed one cycle ahead of the state they belong to
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        sink_d      = sink_q;
        res_valid_d = 1'b0;
        res_code_d  = res_code_q;
        ships_d     = ships_q;
        game_over_d = game_over_q;
        bfs_start_d = bfs_start_q;
        bfs_x_d     = bfs_x_q;
        bfs_y_d     = bfs_y_q;
        rd_valid_d  = 1'b0;
        grant_d     = grant_q;

        case (state_q)
            IDLE: begin
                if (bus.shot_valid && shot_ready_c) begin
                    x_d    = bus.shot_x;
                    y_d    = bus.shot_y;
                    sink_d = 1'b0;
                    if (coord_bad_c) begin
                        state_d     = RESULT;
                        res_valid_d = 1'b1;
                        res_code_d  = CODE_REPEAT;
                    end else begin
                        state_d    = RD_REQ;
                        rd_valid_d = 1'b1;
                    end
                end
            end
            RD_REQ: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.mem_ready) begin
                    if (bus.mem_rd_data == CELL_SUB) begin
                        state_d     = BFS_RUN;
                        bfs_start_d = 1'b1;
                        bfs_x_d     = x_q;
                        bfs_y_d     = y_q;
                        grant_d     = 1'b1;
                    end else begin
                        state_d     = RESULT;
                        res_valid_d = 1'b1;
                        res_code_d  = (bus.mem_rd_data == CELL_WATER) ? CODE_MISS : CODE_REPEAT;
                    end
                end
            end
            BFS_RUN: begin
                if (bus.bfs_done) begin
                    sink_d      = bus.bfs_sink;
                    bfs_start_d = 1'b0;
                    state_d     = BFS_REL;
                end
            end
            BFS_REL: begin
                // Hold the grant until the BFS stage has dropped done, then report
                if (!bus.bfs_done) begin
                    state_d     = RESULT;
                    grant_d     = 1'b0;
                    res_valid_d = 1'b1;
                    res_code_d  = sink_q ? CODE_SINK : CODE_HIT;
                    if (sink_q && (ships_q != '0)) begin
                        ships_d = ships_q - CNT_W'(1);
                        if (ships_q == CNT_W'(1)) begin
                            game_over_d = 1'b1;
                        end
                    end
                end
            end
            RESULT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.shot_ready = shot_ready_c;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_code   = res_code_q;
    assign bus.ships_left = ships_q;
    assign bus.game_over  = game_over_q;
    assign bus.bfs_start  = bfs_start_q;
    assign bus.bfs_x      = bfs_x_q;
    assign bus.bfs_y      = bfs_y_q;

    // Board-memory port: BFS stage passes straight through while it holds the grant
    assign bus.mem_addr_x      = grant_q ? bus.bfs_mem_addr_x   : x_q;
    assign bus.mem_addr_y      = grant_q ? bus.bfs_mem_addr_y   : y_q;
    assign bus.mem_wr_en       = grant_q ? bus.bfs_mem_wr_en    : 1'b0;
    assign bus.mem_wr_data     = grant_q ? bus.bfs_mem_wr_data  : CELL_WATER;
    assign bus.mem_in_valid    = grant_q ? bus.bfs_mem_in_valid : rd_valid_q;
    assign bus.bfs_mem_rd_data = bus.mem_rd_data;
    assign bus.bfs_mem_ready   = grant_q && bus.mem_ready;

endmodule

// File: tb/tb_shot_ctrl.sv
// Directed bench for shot_ctrl with a behavioural board memory and a hand-driven BFS stage.
module tb_shot_ctrl;
    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    shot_ctrl_if #(.CNT_W(3)) bus ();

    shot_ctrl #(.WIDTH(6), .NUM_SHIPS(4), .CNT_W(3)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Board memory model, loader port and activity counters
    logic [1:0] board [8][8];
    logic       ld_clr, ld_en;
    logic [2:0] ld_x, ld_y;
    logic [1:0] ld_v;
    int         mem_lat;
    int         pend = 0;
    int         req_cnt = 0;
    int         wr_cnt = 0;
    int         start_cnt = 0;
    logic       start_prev = 1'b0;

    always @(posedge clk) begin
        bus.mem_ready <= 1'b0;
        if (ld_clr) begin
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    board[i][j] = 2'b00;
        end
        if (ld_en) board[ld_x][ld_y] = ld_v;
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) bus.mem_ready <= 1'b1;
        end
        if (bus.mem_in_valid) begin
            req_cnt = req_cnt + 1;
            bus.mem_rd_data <= board[bus.mem_addr_x][bus.mem_addr_y];
            if (bus.mem_wr_en) begin
                board[bus.mem_addr_x][bus.mem_addr_y] = bus.mem_wr_data;
                wr_cnt = wr_cnt + 1;
            end
            if (mem_lat <= 1) bus.mem_ready <= 1'b1;
            else pend = mem_lat - 1;
        end
        if (bus.bfs_start && !start_prev) start_cnt = start_cnt + 1;
        start_prev = bus.bfs_start;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] x, input logic [2:0] y, input logic [1:0] v);
        ld_x = x; ld_y = y; ld_v = v; ld_en = 1'b1;
        step();
        ld_en = 1'b0;
    endtask

    // Offer a shot in the current cycle T; returns in cycle T+1
    task automatic shot(input logic [2:0] x, input logic [2:0] y);
        bus.shot_x = x; bus.shot_y = y; bus.shot_valid = 1'b1;
        step();
        bus.shot_valid = 1'b0;
    endtask

    // Cycles from shot acceptance to res_valid (called in T+1)
    task automatic wait_res(output int cyc);
        cyc = 1;
        while (!bus.res_valid && cyc < 40) begin
            step();
            cyc++;
        end
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!bus.bfs_start && n < 40) begin
            step();
            n++;
        end
        check({tag, "_bfs_start"}, 8'(bus.bfs_start), 8'd1);
    endtask

    // BFS-side write through the granted port, then done with the given verdict
    task automatic bfs_work(input string tag, input logic [2:0] x, input logic [2:0] y,
                            input logic [1:0] d, input logic sink);
        int n = 0;
        bus.bfs_mem_addr_x = x; bus.bfs_mem_addr_y = y;
        bus.bfs_mem_wr_data = d; bus.bfs_mem_wr_en = 1'b1; bus.bfs_mem_in_valid = 1'b1;
        #1;
        check({tag, "_mux_valid"}, 8'(bus.mem_in_valid), 8'd1);
        check({tag, "_mux_wr"}, 8'(bus.mem_wr_en), 8'd1);
        check({tag, "_mux_addr"}, 8'({bus.mem_addr_x, bus.mem_addr_y}), 8'({x, y}));
        step();
        bus.bfs_mem_in_valid = 1'b0; bus.bfs_mem_wr_en = 1'b0;
        while (!bus.bfs_mem_ready && n < 20) begin
            step();
            n++;
        end
        check({tag, "_bfs_mem_ready"}, 8'(bus.bfs_mem_ready), 8'd1);
        step();
        bus.bfs_done = 1'b1; bus.bfs_sink = sink;
        step();
        check({tag, "_start_drop"}, 8'(bus.bfs_start), 8'd0);
        check({tag, "_no_res_rel"}, 8'(bus.res_valid), 8'd0);
        bus.bfs_done = 1'b0; bus.bfs_sink = 1'b0;
        step();
        check({tag, "_res_valid"}, 8'(bus.res_valid), 8'd1);
        check({tag, "_res_code"}, 8'(bus.res_code), sink ? 8'd2 : 8'd1);
    endtask

    initial begin
        int cyc;
        int req0, wr0, st0, res_seen;

        rstn = 1'b0;
        bus.shot_valid = 1'b0; bus.shot_x = '0; bus.shot_y = '0;
        bus.bfs_done = 1'b0; bus.bfs_sink = 1'b0;
        bus.bfs_mem_addr_x = '0; bus.bfs_mem_addr_y = '0;
        bus.bfs_mem_wr_en = 1'b0; bus.bfs_mem_wr_data = '0; bus.bfs_mem_in_valid = 1'b0;
        ld_clr = 1'b1; ld_en = 1'b0; ld_x = '0; ld_y = '0; ld_v = '0;
        mem_lat = 2;
        step();
        ld_clr = 1'b0;
        load(3'd0, 3'd0, 2'b01);
        load(3'd1, 3'd1, 2'b01);
        load(3'd2, 3'd1, 2'b01);
        load(3'd4, 3'd4, 2'b01);
        for (int i = 0; i < 4; i++) load(3'(i), 3'd5, 2'b01);

        check("rst_shot_ready", 8'(bus.shot_ready), 8'd1);
        check("rst_res_valid", 8'(bus.res_valid), 8'd0);
        check("rst_res_code", 8'(bus.res_code), 8'd0);
        check("rst_ships", 8'(bus.ships_left), 8'd4);
        check("rst_game_over", 8'(bus.game_over), 8'd0);
        check("rst_bfs", 8'({bus.bfs_start, bus.bfs_x, bus.bfs_y}), 8'd0);
        check("rst_mem_valid", 8'(bus.mem_in_valid), 8'd0);
        rstn = 1'b1;
        step();

        // Miss on (2,3), memory latency 2
        req0 = req_cnt; wr0 = wr_cnt;
        shot(3'd2, 3'd3);
        check("miss_rd_valid", 8'(bus.mem_in_valid), 8'd1);
        check("miss_rd_addr", 8'({bus.mem_addr_x, bus.mem_addr_y}), 8'({3'd2, 3'd3}));
        check("miss_rd_wr_en", 8'(bus.mem_wr_en), 8'd0);
        check("miss_busy", 8'(bus.shot_ready), 8'd0);
        wait_res(cyc);
        check("miss_latency", 8'(cyc), 8'd4);
        check("miss_code", 8'(bus.res_code), 8'd0);
        check("miss_ships", 8'(bus.ships_left), 8'd4);
        check("miss_reqs", 8'(req_cnt - req0), 8'd1);
        check("miss_writes", 8'(wr_cnt - wr0), 8'd0);
        step();
        check("miss_res_pulse", 8'(bus.res_valid), 8'd0);
        check("miss_ready_back", 8'(bus.shot_ready), 8'd1);

        // Out-of-range coordinate
        req0 = req_cnt;
        mem_lat = 1;
        shot(3'd7, 3'd0);
        check("inv_no_rd", 8'(bus.mem_in_valid), 8'd0);
        check("inv_res_valid", 8'(bus.res_valid), 8'd1);
        check("inv_code", 8'(bus.res_code), 8'd3);
        step();
        check("inv_ready", 8'(bus.shot_ready), 8'd1);
        check("inv_reqs", 8'(req_cnt - req0), 8'd0);

        // Single-cell sub at (0,0): BFS clears it and reports a sink
        shot(3'd0, 3'd0);
        wait_start("sink1");
        check("sink1_bfs_xy", 8'({bus.bfs_x, bus.bfs_y}), 8'd0);
        bfs_work("sink1", 3'd0, 3'd0, 2'b00, 1'b1);
        check("sink1_ships", 8'(bus.ships_left), 8'd3);
        check("sink1_cell", 8'(board[0][0]), 8'd0);
        step();

        // Two-cell sub: hit (1,1) without sink, then re-shoot it
        shot(3'd1, 3'd1);
        wait_start("hit");
        check("hit_bfs_xy", 8'({bus.bfs_x, bus.bfs_y}), 8'({3'd1, 3'd1}));
        bfs_work("hit", 3'd1, 3'd1, 2'b10, 1'b0);
        check("hit_ships", 8'(bus.ships_left), 8'd3);
        check("hit_cell", 8'(board[1][1]), 8'd2);
        step();
        st0 = start_cnt;
        shot(3'd1, 3'd1);
        wait_res(cyc);
        check("rep_latency", 8'(cyc), 8'd3);
        check("rep_code", 8'(bus.res_code), 8'd3);
        check("rep_no_bfs", 8'(start_cnt - st0), 8'd0);
        step();

        // Reset while the BFS stage owns the memory port
        shot(3'd4, 3'd4);
        wait_start("rst");
        bus.bfs_mem_addr_x = 3'd4; bus.bfs_mem_addr_y = 3'd4; bus.bfs_mem_in_valid = 1'b1;
        #1;
        check("rst_mid_granted", 8'(bus.mem_in_valid), 8'd1);
        rstn = 1'b0;
        #1;
        check("rst_mid_start", 8'(bus.bfs_start), 8'd0);
        check("rst_mid_valid", 8'(bus.mem_in_valid), 8'd0);
        check("rst_mid_ships", 8'(bus.ships_left), 8'd4);
        bus.bfs_mem_in_valid = 1'b0;
        step();
        rstn = 1'b1;
        step();
        check("rst_rel_ready", 8'(bus.shot_ready), 8'd1);
        check("rst_rel_res", 8'(bus.res_valid), 8'd0);

        // Sink all four remaining-count ships to reach game over
        for (int i = 0; i < 4; i++) begin
            shot(3'(i), 3'd5);
            wait_start("go");
            bfs_work("go", 3'(i), 3'd5, 2'b00, 1'b1);
            check("go_ships", 8'(bus.ships_left), 8'(3 - i));
            check("go_flag", 8'(bus.game_over), (i == 3) ? 8'd1 : 8'd0);
            step();
        end
        check("go_ready_low", 8'(bus.shot_ready), 8'd0);
        req0 = req_cnt; res_seen = 0;
        bus.shot_x = 3'd4; bus.shot_y = 3'd4; bus.shot_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.res_valid || bus.mem_in_valid) res_seen++;
        end
        bus.shot_valid = 1'b0;
        check("go_ignored", 8'(res_seen), 8'd0);
        check("go_no_reqs", 8'(req_cnt - req0), 8'd0);
        check("go_ready_held", 8'(bus.shot_ready), 8'd0);
        check("go_ships_zero", 8'(bus.ships_left), 8'd0);
        check("go_sticky", 8'(bus.game_over), 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
